control_unit: RTL and testbench

- Main instruction decoder for the RV32I 5-stage pipelined CPU.
- Takes the 7-bit opcode of the instruction in the decode stage.
- Produces the register-file, memory, branch, operand-select, immediate-select, next-PC and ALU-class control signals.
- Outputs are registered into the ID/EX boundary: one cycle of latency, cleared to a NOP bundle by reset.

---
 rtl/control_unit.sv | 121 ++++++++++++
 tb/tb_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main RV32I opcode decoder. The control bundle is registered at the ID/EX boundary.
// Illegal or unknown opcodes produce the all-zero NOP bundle.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    output logic       write,
    output logic       store,
    output logic       load,
    output logic       branch,
    output logic [1:0] alu_operand_a_selector,
    output logic       alu_operand_b_selector,
    output logic [1:0] immediate_selector,
    output logic [1:0] next_pc_selector,
    output logic [2:0] alu_operations_selector
);

    logic       write_d;
    logic       store_d;
    logic       load_d;
    logic       branch_d;
    logic [1:0] a_sel_d;
    logic       b_sel_d;
    logic [1:0] imm_sel_d;
    logic [1:0] npc_sel_d;
    logic [2:0] alu_op_d;

    // A plain case never matches an opcode containing X/Z, so unknowns fall into the NOP default.
    always_comb begin
        write_d   = 1'b0;
        store_d   = 1'b0;
        load_d    = 1'b0;
        branch_d  = 1'b0;
        a_sel_d   = 2'b00;
        b_sel_d   = 1'b0;
        imm_sel_d = 2'b00;
        npc_sel_d = 2'b00;
        alu_op_d  = 3'b000;
        case (opcode)
            7'h33: begin
                write_d  = 1'b1;
                alu_op_d = 3'b001;
            end
            7'h03: begin
                write_d = 1'b1;
                load_d  = 1'b1;
                b_sel_d = 1'b1;
            end
            7'h13: begin
                write_d  = 1'b1;
                b_sel_d  = 1'b1;
                alu_op_d = 3'b010;
            end
            7'h67: begin
                write_d   = 1'b1;
                b_sel_d   = 1'b1;
                npc_sel_d = 2'b10;
            end
            7'h23: begin
                store_d   = 1'b1;
                b_sel_d   = 1'b1;
                imm_sel_d = 2'b01;
            end
            7'h63: begin
                branch_d  = 1'b1;
                a_sel_d   = 2'b01;
                b_sel_d   = 1'b1;
                imm_sel_d = 2'b10;
                npc_sel_d = 2'b01;
                alu_op_d  = 3'b011;
            end
            7'h17: begin
                write_d   = 1'b1;
                a_sel_d   = 2'b01;
                b_sel_d   = 1'b1;
                imm_sel_d = 2'b11;
            end
            7'h37: begin
                write_d   = 1'b1;
                a_sel_d   = 2'b10;
                b_sel_d   = 1'b1;
                imm_sel_d = 2'b11;
                alu_op_d  = 3'b100;
            end
            7'h6F: begin
                write_d   = 1'b1;
                a_sel_d   = 2'b01;
                b_sel_d   = 1'b1;
                imm_sel_d = 2'b11;
                npc_sel_d = 2'b10;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write                   <= 1'b0;
            store                   <= 1'b0;
            load                    <= 1'b0;
            branch                  <= 1'b0;
            alu_operand_a_selector  <= 2'b00;
            alu_operand_b_selector  <= 1'b0;
            immediate_selector      <= 2'b00;
            next_pc_selector        <= 2'b00;
            alu_operations_selector <= 3'b000;
        end else begin
            write                   <= write_d;
            store                   <= store_d;
            load                    <= load_d;
            branch                  <= branch_d;
            alu_operand_a_selector  <= a_sel_d;
            alu_operand_b_selector  <= b_sel_d;
            immediate_selector      <= imm_sel_d;
            next_pc_selector        <= npc_sel_d;
            alu_operations_selector <= alu_op_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table-lookup reference model with directed and random opcodes.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [1:0] imm_sel;
    logic [1:0] npc_sel;
    logic [2:0] alu_op;

    logic [13:0] obs;
    logic [13:0] rows [logic [6:0]];
    int n_checks;
    int n_fail;

    control_unit dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .opcode                  (opcode),
        .write                   (write),
        .store                   (store),
        .load                    (load),
        .branch                  (branch),
        .alu_operand_a_selector  (a_sel),
        .alu_operand_b_selector  (b_sel),
        .immediate_selector      (imm_sel),
        .next_pc_selector        (npc_sel),
        .alu_operations_selector (alu_op)
    );

    // Bundle order: write, store, load, branch, a_sel, b_sel, imm_sel, npc_sel, alu_op
    assign obs = {write, store, load, branch, a_sel, b_sel, imm_sel, npc_sel, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] model(input logic [6:0] op);
        if (rows.exists(op))
            return rows[op];
        return 14'b0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            assert ((32'(store) + 32'(load) + 32'(branch)) <= 1 && !(write && (store || branch)))
            else begin
                n_fail++;
                $display("FAIL invariant w=%b s=%b l=%b b=%b required mutually exclusive", write, store, load, branch);
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        opcode = 7'h33;
        #3;
        n_checks++;
        if (obs !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_immediate got=%b want=%b", obs, 14'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b want=%b", obs, 14'b0);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 14'b1_0_0_0_00_0_00_00_001) begin
            n_fail++;
            $display("FAIL reset_release got=%b want=%b", obs, 14'b1_0_0_0_00_0_00_00_001);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] ops [11];
        ops = '{7'h00, 7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h7F};
        for (int i = 0; i < 11; i++) begin
            opcode = ops[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== model(ops[i])) begin
                n_fail++;
                $display("FAIL sweep op=%02h got=%b want=%b", ops[i], obs, model(ops[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        opcode = 7'h63;
        @(posedge clk);
        #1;
        n_checks++;
        if (branch !== 1'b1 || a_sel !== 2'b01 || imm_sel !== 2'b10 || npc_sel !== 2'b01 || alu_op !== 3'b011) begin
            n_fail++;
            $display("FAIL b2b_branch got=%b want=%b", obs, 14'b0_0_0_1_01_1_10_01_011);
        end
        opcode = 7'h23;
        @(posedge clk);
        #1;
        n_checks++;
        if (store !== 1'b1 || imm_sel !== 2'b01 || npc_sel !== 2'b00 || branch !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_store got=%b want=%b", obs, 14'b0_1_0_0_00_1_01_00_000);
        end
    endtask

    task automatic test_jumps();
        opcode = 7'h6F;
        @(posedge clk);
        #1;
        n_checks++;
        if (write !== 1'b1 || a_sel !== 2'b01 || imm_sel !== 2'b11 || npc_sel !== 2'b10 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL jal got=%b want=%b", obs, 14'b1_0_0_0_01_1_11_10_000);
        end
        opcode = 7'h67;
        @(posedge clk);
        #1;
        n_checks++;
        if (write !== 1'b1 || a_sel !== 2'b00 || imm_sel !== 2'b00 || npc_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL jalr got=%b want=%b", obs, 14'b1_0_0_0_00_1_00_10_000);
        end
    endtask

    task automatic test_async_reset();
        opcode = 7'h03;
        @(posedge clk);
        #1;
        n_checks++;
        if (load !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_load got=%b want=%b", load, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'b0) begin
            n_fail++;
            $display("FAIL async_clear got=%b want=%b", obs, 14'b0);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== model(7'h03)) begin
            n_fail++;
            $display("FAIL async_recover got=%b want=%b", obs, model(7'h03));
        end
    endtask

    task automatic test_illegal_x();
        opcode = 7'b0x10011;
        #1;
        if ($isunknown(opcode)) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== 14'b0) begin
                n_fail++;
                $display("FAIL x_opcode got=%b want=%b", obs, 14'b0);
            end
        end
        opcode = 7'h0B;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 14'b0) begin
            n_fail++;
            $display("FAIL illegal_0b got=%b want=%b", obs, 14'b0);
        end
    endtask

    task automatic test_random();
        logic [6:0] legal [9];
        logic [6:0] op;
        legal = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0)
                op = legal[$urandom_range(0, 8)];
            else
                op = 7'($urandom_range(0, 127));
            opcode = op;
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== model(op)) begin
                n_fail++;
                $display("FAIL random op=%02h got=%b want=%b", op, obs, model(op));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rows[7'h33] = 14'b1_0_0_0_00_0_00_00_001;
        rows[7'h03] = 14'b1_0_1_0_00_1_00_00_000;
        rows[7'h13] = 14'b1_0_0_0_00_1_00_00_010;
        rows[7'h67] = 14'b1_0_0_0_00_1_00_10_000;
        rows[7'h23] = 14'b0_1_0_0_00_1_01_00_000;
        rows[7'h63] = 14'b0_0_0_1_01_1_10_01_011;
        rows[7'h17] = 14'b1_0_0_0_01_1_11_00_000;
        rows[7'h37] = 14'b1_0_0_0_10_1_11_00_100;
        rows[7'h6F] = 14'b1_0_0_0_01_1_11_10_000;

        test_reset();
        test_sweep();
        test_back_to_back();
        test_jumps();
        test_async_reset();
        test_illegal_x();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
